io_read_resp: RTL and testbench
===============================

Name: io_read_resp

Overview:
- Read-side responder for the processor's memory-mapped IO space; it is the read counterpart of the write-enable decoder.
- Accepts a CPU load (address + request) and classifies the address into a region: data memory, show/status register, original-image buffer or processed-image buffer.
- Issues a one-cycle read enable with a region-relative offset, waits the region's fixed latency, and returns the data with a one-cycle valid pulse.
- Stalls the single-cycle CPU while the read is in flight.

Parameters:
- ADDR_W, 22, address width
- DATA_W, 32, data width
- MEM_LAT, 1, data-memory read latency in cycles (re to rdata valid)
- IMG_LAT, 2, original/processed image buffer read latency in cycles

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  CPU load request, level, held while stall=1
- rd_addr  in  ADDR_W  CPU load address
- mem_rdata  in  DATA_W  data memory read data
- show_status  in  DATA_W  show/status register value
- orig_rdata  in  DATA_W  original-image buffer read data
- proc_rdata  in  DATA_W  processed-image buffer read data
- mem_re  out  1  data memory read enable
- orig_re  out  1  original buffer read enable
- proc_re  out  1  processed buffer read enable
- sub_addr  out  ADDR_W  offset of the address within its region
- rd_data  out  DATA_W  returned load data
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_err  out  1  pulses with rd_valid when the address is unmapped
- stall  out  1  CPU hold

Behaviour:
- Address map (first match wins):
  - MEM: addr<=96, base 0
  - SHOW: addr==116
  - ORIG: 120..129, base 120
  - PROC: 130..140, base 130
  - Anything else is UNMAPPED (97..115, 117..119, >140).
- Reset: FSM goes to IDLE. All outputs are 0, including rd_data, sub_addr and the counter.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - stall = rd_req (combinational).
  - When rd_req=1 (cycle N): latch the region and sub_addr = rd_addr - base; go to ACCESS.
- ACCESS (cycle N+1):
  - Assert exactly one of mem_re/orig_re/proc_re for one cycle. SHOW and UNMAPPED assert none.
  - Load the counter with the region latency: MEM_LAT, IMG_LAT, or 0 for SHOW/UNMAPPED.
  - If the latency is 0, capture now; otherwise go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture the selected rdata into rd_data and go to RESP.
- Capture sources:
  - MEM/ORIG/PROC: the matching rdata.
  - SHOW: show_status.
  - UNMAPPED: 0, and rd_err is set.
- RESP:
  - rd_valid=1 and stall=0 for exactly one cycle; rd_err is valid in this cycle.
  - rd_req is ignored in RESP, because the CPU completes the load on this edge.
  - Next state is IDLE.
- Latency: rd_valid is asserted in cycle N+2+LAT.
  - MEM: N+3. ORIG/PROC: N+4. SHOW/UNMAPPED: N+2.
- stall is 1 from cycle N through the last cycle before RESP, and 0 in RESP and in IDLE without a request.
- sub_addr stays stable from ACCESS through capture. rd_data holds its value after RESP until the next capture.
- rd_addr changes while stall=1 are ignored; the latched values are used.
- Back-to-back loads: a new request is accepted in IDLE on the cycle after RESP.
- Reset mid-transaction: the transaction is dropped and no rd_valid is produced. Any re already issued is harmless.
- Counter width: $clog2(max(MEM_LAT,IMG_LAT)+1). Parameter values of 0 are legal and skip WAIT.

Decomposition:
- Package io_map_pkg holds:
  - constants MEM_LAST=96, SHOW_ADDR=116, ORIG_BASE=120, ORIG_LAST=129, PROC_BASE=130, PROC_LAST=140
  - typedef enum region_t {REG_MEM, REG_SHOW, REG_ORIG, REG_PROC, REG_NONE}
  - the FSM state enum
- One combinational sub-module, io_region_classify: input addr; outputs region_t and the base offset. It is shared conceptually with the write decoder's map.

Test Plan:
- Reset, then hold idle → all outputs 0, stall=0.
- MEM read:
  - Stimulus: rd_req with addr=40 at N; mem_rdata=0xDEADBEEF at N+2.
  - Required response: mem_re only at N+1 with sub_addr=40; stall=1 over N..N+2; rd_valid at N+3 with rd_data=0xDEADBEEF and rd_err=0.
- ORIG/PROC reads:
  - addr=125 → orig_re at N+1, sub_addr=5, rd_valid at N+4.
  - addr=140 → proc_re, sub_addr=10.
  - addr=141 → UNMAPPED.
- SHOW and unmapped reads:
  - addr=116, show_status=0x1 → rd_valid at N+2, rd_data=1, no re.
  - addr=100 → rd_valid at N+2, rd_data=0, rd_err=1.
  - addr=96 → MEM. addr=97 → error.
- Back-to-back and address-change cases:
  - Two MEM loads with rd_req held high → the second is accepted the cycle after RESP; each response is correct.
  - rd_addr changed mid-stall → no effect on the result.
- Reset during an ORIG read → assert rst at N+2 → no rd_valid; outputs 0; the next request completes normally.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared IO address map for the memory-mapped load/store path.
// Region boundaries, region encoding and the read-responder FSM states.
package io_map_pkg;

    localparam int unsigned MEM_LAST  = 96;
    localparam int unsigned SHOW_ADDR = 116;
    localparam int unsigned ORIG_BASE = 120;
    localparam int unsigned ORIG_LAST = 129;
    localparam int unsigned PROC_BASE = 130;
    localparam int unsigned PROC_LAST = 140;

    typedef enum logic [2:0] {
        REG_MEM,
        REG_SHOW,
        REG_ORIG,
        REG_PROC,
        REG_NONE
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/io_region_classify.sv
// Combinational address classifier: maps a CPU address to its IO region
// and the region's base address (first match wins).
module io_region_classify
    import io_map_pkg::*;
#(
    parameter int ADDR_W = 22
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [ADDR_W-1:0] base
);

    // SHOW uses its own address as base; unmapped addresses pass through unchanged.
    always_comb begin
        region = REG_NONE;
        base   = '0;
        if (addr <= ADDR_W'(MEM_LAST)) begin
            region = REG_MEM;
        end else if (addr == ADDR_W'(SHOW_ADDR)) begin
            region = REG_SHOW;
            base   = ADDR_W'(SHOW_ADDR);
        end else if (addr >= ADDR_W'(ORIG_BASE) && addr <= ADDR_W'(ORIG_LAST)) begin
            region = REG_ORIG;
            base   = ADDR_W'(ORIG_BASE);
        end else if (addr >= ADDR_W'(PROC_BASE) && addr <= ADDR_W'(PROC_LAST)) begin
            region = REG_PROC;
            base   = ADDR_W'(PROC_BASE);
        end
    end

endmodule

// File: rtl/io_read_resp.sv
// Read-side responder for the memory-mapped IO space: classifies a CPU load,
// issues a region read enable, waits the region latency and returns the data.
module io_read_resp
    import io_map_pkg::*;
#(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int IMG_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] show_status,
    input  logic [DATA_W-1:0] orig_rdata,
    input  logic [DATA_W-1:0] proc_rdata,
    output logic              mem_re,
    output logic              orig_re,
    output logic              proc_re,
    output logic [ADDR_W-1:0] sub_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              stall
);

    localparam int MAX_LAT = (MEM_LAT > IMG_LAT) ? MEM_LAT : IMG_LAT;
    localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    state_t            state;
    region_t           region;
    region_t           cls_region;
    logic [ADDR_W-1:0] cls_base;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  lat;
    logic [DATA_W-1:0] cap_data;
    logic              capture;

    io_region_classify #(
        .ADDR_W (ADDR_W)
    ) u_classify (
        .addr   (rd_addr),
        .region (cls_region),
        .base   (cls_base)
    );

    always_comb begin
        lat = '0;
        case (region)
            REG_MEM:           lat = CNT_W'(MEM_LAT);
            REG_ORIG, REG_PROC: lat = CNT_W'(IMG_LAT);
            default:           lat = '0;
        endcase
    end

    always_comb begin
        cap_data = '0;
        case (region)
            REG_MEM:  cap_data = mem_rdata;
            REG_SHOW: cap_data = show_status;
            REG_ORIG: cap_data = orig_rdata;
            REG_PROC: cap_data = proc_rdata;
            default:  cap_data = '0;
        endcase
    end

    // Zero-latency regions capture straight out of ACCESS; others on the last WAIT cycle.
    assign capture = ((state == ST_ACCESS) && (lat == '0)) ||
                     ((state == ST_WAIT) && (cnt <= CNT_W'(1)));

    assign stall = (state == ST_IDLE) ? rd_req : (state != ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            region   <= REG_NONE;
            cnt      <= '0;
            mem_re   <= 1'b0;
            orig_re  <= 1'b0;
            proc_re  <= 1'b0;
            sub_addr <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            mem_re   <= 1'b0;
            orig_re  <= 1'b0;
            proc_re  <= 1'b0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        region   <= cls_region;
                        sub_addr <= rd_addr - cls_base;
                        mem_re   <= (cls_region == REG_MEM);
                        orig_re  <= (cls_region == REG_ORIG);
                        proc_re  <= (cls_region == REG_PROC);
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt   <= lat;
                    state <= (lat == '0) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture) begin
                        cnt   <= '0;
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (capture) begin
                rd_data  <= cap_data;
                rd_valid <= 1'b1;
                rd_err   <= (region == REG_NONE);
            end
        end
    end

endmodule

// File: tb/tb_io_read_resp.sv
// Scoreboard bench for io_read_resp: directed loads push expected responses,
// a negedge monitor pops and checks data, error flag and arrival cycle.
module tb_io_read_resp;

    localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [21:0] rd_addr;
    logic [31:0] mem_rdata;
    logic [31:0] show_status;
    logic [31:0] orig_rdata;
    logic [31:0] proc_rdata;
    logic        mem_re;
    logic        orig_re;
    logic        proc_re;
    logic [21:0] sub_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic        stall;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    io_read_resp #(
        .ADDR_W  (22),
        .DATA_W  (32),
        .MEM_LAT (1),
        .IMG_LAT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .mem_rdata   (mem_rdata),
        .show_status (show_status),
        .orig_rdata  (orig_rdata),
        .proc_rdata  (proc_rdata),
        .mem_re      (mem_re),
        .orig_re     (orig_re),
        .proc_re     (proc_re),
        .sub_addr    (sub_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_err      (rd_err),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setSources(input int src, input logic [31:0] val);
        mem_rdata   = (src == 0) ? val : JUNK;
        show_status = (src == 1) ? val : JUNK;
        orig_rdata  = (src == 2) ? val : JUNK;
        proc_rdata  = (src == 3) ? val : JUNK;
    endtask

    // src: 0 mem, 1 show, 2 orig, 3 proc, 4 unmapped; exp_re is {proc,orig,mem}.
    task automatic applyStimulus(input logic [21:0] addr, input int src, input int lat,
                                 input logic [31:0] val, input logic [2:0] exp_re,
                                 input bit chk_sub, input logic [21:0] exp_sub,
                                 input bit hold, input bit scramble);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        n       = cyc;
        rd_addr = addr;
        rd_req  = 1'b1;
        setSources(-1, JUNK);
        e.data = (src == 4) ? 32'h0 : val;
        e.err  = (src == 4);
        e.cyc  = n + 2 + lat;
        sb_q.push_back(e);
        @(negedge clk);
        checkOutput("stall_req", 64'(stall), 64'd1);
        @(posedge clk); #1;
        if (scramble) rd_addr = 22'd125;
        if (lat == 0) setSources(src, val);
        @(negedge clk);
        checkOutput("re_access", 64'({proc_re, orig_re, mem_re}), 64'(exp_re));
        checkOutput("stall_access", 64'(stall), 64'd1);
        if (chk_sub) checkOutput("sub_addr", 64'(sub_addr), 64'(exp_sub));
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == lat) setSources(src, val);
            @(negedge clk);
            checkOutput("re_wait", 64'({proc_re, orig_re, mem_re}), 64'd0);
            checkOutput("stall_wait", 64'(stall), 64'd1);
            if (chk_sub) checkOutput("sub_addr_wait", 64'(sub_addr), 64'(exp_sub));
        end
        @(posedge clk); #1;
        setSources(-1, JUNK);
        rd_req = hold;
        @(negedge clk);
        checkOutput("stall_resp", 64'(stall), 64'd0);
    endtask

    // Every rd_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got rd_valid=1 data 0x%0h, expected no response (cycle %0d)", rd_data, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("rd_data", 64'(rd_data), 64'(e.data));
                checkOutput("rd_err", 64'(rd_err), 64'(e.err));
                checkOutput("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        setSources(-1, JUNK);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_outputs", 64'({mem_re, orig_re, proc_re, rd_valid, rd_err, stall}), 64'd0);
        checkOutput("idle_rd_data", 64'(rd_data), 64'd0);
        checkOutput("idle_sub_addr", 64'(sub_addr), 64'd0);

        applyStimulus(22'd40,  0, 1, 32'hDEAD_BEEF, 3'b001, 1'b1, 22'd40, 1'b0, 1'b0);
        applyStimulus(22'd125, 2, 2, 32'h1234_5678, 3'b010, 1'b1, 22'd5,  1'b0, 1'b0);
        applyStimulus(22'd140, 3, 2, 32'hCAFE_F00D, 3'b100, 1'b1, 22'd10, 1'b0, 1'b0);
        applyStimulus(22'd141, 4, 0, 32'h0,         3'b000, 1'b0, 22'd0,  1'b0, 1'b0);
        applyStimulus(22'd116, 1, 0, 32'h0000_0001, 3'b000, 1'b0, 22'd0,  1'b0, 1'b0);
        applyStimulus(22'd100, 4, 0, 32'h0,         3'b000, 1'b0, 22'd0,  1'b0, 1'b0);
        applyStimulus(22'd96,  0, 1, 32'h0000_0096, 3'b001, 1'b1, 22'd96, 1'b0, 1'b0);
        applyStimulus(22'd97,  4, 0, 32'h0,         3'b000, 1'b0, 22'd0,  1'b0, 1'b0);
        applyStimulus(22'd120, 2, 2, 32'h0BAD_F00D, 3'b010, 1'b1, 22'd0,  1'b0, 1'b0);
        applyStimulus(22'd130, 3, 2, 32'h5555_AAAA, 3'b100, 1'b1, 22'd0,  1'b0, 1'b0);

        @(negedge clk);
        checkOutput("rd_data_hold", 64'(rd_data), 64'h5555_AAAA);

        applyStimulus(22'd10, 0, 1, 32'h1010_1010, 3'b001, 1'b1, 22'd10, 1'b1, 1'b0);
        applyStimulus(22'd20, 0, 1, 32'h2020_2020, 3'b001, 1'b1, 22'd20, 1'b0, 1'b0);

        applyStimulus(22'd50, 0, 1, 32'h5050_5050, 3'b001, 1'b1, 22'd50, 1'b0, 1'b1);

        // Reset two cycles into an ORIG read: the load must vanish without a response.
        @(posedge clk); #1;
        rd_addr = 22'd125;
        rd_req  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst    = 1'b1;
        rd_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_outputs", 64'({mem_re, orig_re, proc_re, rd_valid, rd_err, stall}), 64'd0);
        checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
        checkOutput("rst_sub_addr", 64'(sub_addr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_stall", 64'(stall), 64'd0);

        applyStimulus(22'd127, 2, 2, 32'h7777_0127, 3'b010, 1'b1, 22'd7, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
